// File: rtl/uart_pkg.sv
// Shared UART types: arbiter state encoding and small sizing helpers.
package uart_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } uart_arb_state_t;

    localparam int unsigned UART_DATA_W = 8;

    // $clog2 that never returns 0, so a 1-value range still gets a 1-bit vector.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping mod N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_any
);

    // Scan offsets from farthest to nearest so the nearest requester to i_ptr wins last.
    always_comb begin
        logic [IW-1:0] w_pos;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_pos     = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_pos = IW'((int'(i_ptr) + i) % int'(N));
            if (i_req[w_pos]) begin
                o_gnt_any = 1'b1;
                o_gnt_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between NUM_REQ byte streams.
// A grant is held for a whole packet or MAX_BURST bytes; the FIFO is never written when full.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 i_req_en,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ-1:0][UART_DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]                 i_req_last,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    input  logic                               i_fifo_full,
    input  logic                               i_fifo_clear,
    output logic                               o_fifo_wr_en,
    output logic [UART_DATA_W-1:0]             o_fifo_wr_data,
    output logic                               o_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]         o_grant_idx,
    output logic                               o_abort
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2_min1(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    uart_arb_state_t  r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_abort;

    logic [NUM_REQ-1:0] w_cand;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic               w_granted;
    logic               w_holder_en;
    logic               w_ready;
    logic               w_xfer;
    logic               w_burst_hit;
    logic               w_release;
    logic               w_drop;
    logic [IDX_W-1:0]   w_next_ptr;

    assign w_cand = i_req_valid & i_req_en;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .i_req     (w_cand),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_win_idx),
        .o_gnt_any (w_win_any)
    );

    // Zero-latency handshake to the FIFO so a full flag is never acted on late.
    always_comb begin
        w_granted   = (r_state == ARB_GRANT);
        w_holder_en = i_req_en[r_grant_idx];
        w_ready     = w_granted && !i_fifo_full && !i_fifo_clear && w_holder_en;
        w_xfer      = w_ready && i_req_valid[r_grant_idx];
        w_burst_hit = (MAX_BURST != 0) && (r_burst_cnt == BURST_LAST);
        w_release   = w_xfer && (i_req_last[r_grant_idx] || w_burst_hit);
        w_drop      = w_granted && (i_fifo_clear || !w_holder_en);
        w_next_ptr  = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

        o_req_ready              = '0;
        o_req_ready[r_grant_idx] = w_ready;
        o_fifo_wr_en             = w_xfer;
        o_fifo_wr_data           = w_xfer ? i_req_data[r_grant_idx] : '0;
        o_grant_valid            = w_granted;
        o_grant_idx              = r_grant_idx;
        o_abort                  = r_abort;
    end

    // Grant FSM: arbitrate in IDLE, hold in GRANT until last byte, burst limit, or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_any && !i_fifo_clear) begin
                        r_grant_idx <= w_win_idx;
                        r_burst_cnt <= '0;
                        r_state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_drop) begin
                        // Holder lost the port mid-packet; it drops to lowest priority.
                        r_state  <= ARB_IDLE;
                        r_abort  <= 1'b1;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_xfer) begin
                        // Saturates only in unlimited mode; otherwise release comes first.
                        if (r_burst_cnt != '1) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                        if (w_release) begin
                            r_state  <= ARB_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
